// File: rtl/alu_commit_stage.sv
// Commit stage behind the ALU: holds up to two pending results, retires them in order
// into the register file / flags register, and forwards pending values to the read ports.
package alu_commit_pkg;
    typedef struct packed {
        logic Carry;
        logic Zero;
        logic Negative;
        logic Overflow;
        logic Parity;
    } sFlags;
endpackage

module alu_commit_stage
    import alu_commit_pkg::*;
#(
    parameter int DataWidth    = 16,
    parameter int RegAddrWidth = 3,
    parameter int Depth        = 2
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [RegAddrWidth-1:0] InDestIdx,
    input  logic [DataWidth-1:0]    InResult,
    input  sFlags                   InFlags,
    input  logic                    InWriteReg,
    input  logic                    InWriteFlags,
    input  logic                    CommitEnable,
    input  logic [RegAddrWidth-1:0] SrcIdx,
    input  logic [RegAddrWidth-1:0] DestIdx,
    output logic [DataWidth-1:0]    SrcData,
    output logic [DataWidth-1:0]    DestData,
    output sFlags                   CurFlags,
    output logic [1:0]              PendingCount
);

    localparam int RegCount = 2 ** RegAddrWidth;

    typedef struct packed {
        logic [RegAddrWidth-1:0] idx;
        logic [DataWidth-1:0]    result;
        sFlags                   flags;
        logic                    wr_reg;
        logic                    wr_flags;
    } entry_t;

    // pend[0] is always the oldest entry, pend[1] the youngest when count == 2
    entry_t                 pend [Depth];
    logic [1:0]             count;
    logic [DataWidth-1:0]   regfile [RegCount];
    sFlags                  flags_reg;

    logic                   accept;
    logic                   commit;
    logic                   wpos;
    entry_t                 in_entry;

    assign InReady      = (count < 2'd2);
    assign PendingCount = count;
    assign accept       = InValid && InReady;
    assign commit       = CommitEnable && (count != 2'd0);

    always_comb begin
        in_entry          = '0;
        in_entry.idx      = InDestIdx;
        in_entry.result   = InResult;
        in_entry.flags    = InFlags;
        in_entry.wr_reg   = InWriteReg;
        in_entry.wr_flags = InWriteFlags;
        // slot for the new entry accounts for the shift caused by a same-edge commit
        wpos = commit ? (count == 2'd2) : (count == 2'd1);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count     <= '0;
            flags_reg <= '0;
            for (int unsigned i = 0; i < RegCount; i++) regfile[i] <= '0;
            for (int unsigned i = 0; i < Depth; i++)    pend[i]    <= '0;
        end else begin
            if (commit) begin
                if (pend[0].wr_reg)   regfile[pend[0].idx] <= pend[0].result;
                if (pend[0].wr_flags) flags_reg            <= pend[0].flags;
                pend[0] <= pend[1];
            end
            if (accept) pend[wpos] <= in_entry;
            count <= count + {1'b0, accept} - {1'b0, commit};
        end
    end

    logic [RegAddrWidth-1:0] rd_idx  [2];
    logic [DataWidth-1:0]    rd_data [2];

    assign rd_idx[0] = SrcIdx;
    assign rd_idx[1] = DestIdx;
    assign SrcData   = rd_data[0];
    assign DestData  = rd_data[1];

    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            rd_data[p] = regfile[rd_idx[p]];
            if (count == 2'd2 && pend[1].wr_reg && pend[1].idx == rd_idx[p])
                rd_data[p] = pend[1].result;
            else if (count != 2'd0 && pend[0].wr_reg && pend[0].idx == rd_idx[p])
                rd_data[p] = pend[0].result;
        end
    end

    always_comb begin
        CurFlags = flags_reg;
        if (count == 2'd2 && pend[1].wr_flags)
            CurFlags = pend[1].flags;
        else if (count != 2'd0 && pend[0].wr_flags)
            CurFlags = pend[0].flags;
    end

endmodule

// File: tb/tb_alu_commit_stage.sv
// Self-checking bench for alu_commit_stage: directed scenarios followed by random traffic,
// compared every cycle against a queue-based reference model.
module tb_alu_commit_stage;
    import alu_commit_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [2:0]  InDestIdx;
    logic [15:0] InResult;
    sFlags       InFlags;
    logic        InWriteReg;
    logic        InWriteFlags;
    logic        CommitEnable;
    logic [2:0]  SrcIdx;
    logic [2:0]  DestIdx;
    logic [15:0] SrcData;
    logic [15:0] DestData;
    sFlags       CurFlags;
    logic [1:0]  PendingCount;

    alu_commit_stage #(.DataWidth(16), .RegAddrWidth(3), .Depth(2)) dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .InDestIdx(InDestIdx), .InResult(InResult), .InFlags(InFlags),
        .InWriteReg(InWriteReg), .InWriteFlags(InWriteFlags), .CommitEnable(CommitEnable),
        .SrcIdx(SrcIdx), .DestIdx(DestIdx), .SrcData(SrcData), .DestData(DestData),
        .CurFlags(CurFlags), .PendingCount(PendingCount)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [2:0]  idx;
        logic [15:0] res;
        sFlags       fl;
        bit          wr;
        bit          wf;
    } ent_t;

    ent_t        q[$];
    logic [15:0] rf [8];
    sFlags       fr;
    bit          model_valid = 0;
    int          tests = 0;
    int          fails = 0;

    function automatic logic [15:0] m_read(input logic [2:0] i);
        for (int k = q.size() - 1; k >= 0; k--)
            if (q[k].wr && q[k].idx == i) return q[k].res;
        return rf[i];
    endfunction

    function automatic sFlags m_flags();
        for (int k = q.size() - 1; k >= 0; k--)
            if (q[k].wf) return q[k].fl;
        return fr;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [2:0] idx, input logic [15:0] res,
                         input logic [4:0] fl, input bit wr, input bit wf, input bit ce);
        InValid = v; InDestIdx = idx; InResult = res; InFlags = fl;
        InWriteReg = wr; InWriteFlags = wf; CommitEnable = ce;
    endtask

    // compare outputs mid-cycle, then advance one edge and update the model
    task automatic tick();
        bit acc, com;
        ent_t e;
        #4;
        if (model_valid) begin
            chk("ready", 32'(InReady), 32'(q.size() < 2));
            chk("count", 32'(PendingCount), 32'(q.size()));
            chk("src",   32'(SrcData), 32'(m_read(SrcIdx)));
            chk("dest",  32'(DestData), 32'(m_read(DestIdx)));
            chk("flags", 32'(CurFlags), 32'(m_flags()));
        end
        acc = InValid && (q.size() < 2);
        com = CommitEnable && (q.size() > 0);
        e.idx = InDestIdx; e.res = InResult; e.fl = InFlags;
        e.wr = InWriteReg; e.wf = InWriteFlags;
        @(posedge Clock);
        if (Reset) begin
            q.delete();
            for (int i = 0; i < 8; i++) rf[i] = '0;
            fr = '0;
            model_valid = 1;
        end else begin
            if (com) begin
                if (q[0].wr) rf[q[0].idx] = q[0].res;
                if (q[0].wf) fr = q[0].fl;
                void'(q.pop_front());
            end
            if (acc) q.push_back(e);
        end
        #1;
    endtask

    initial begin
        Reset = 1'b1; SrcIdx = '0; DestIdx = '0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        Reset = 1'b0;
        #1;
        chk("rst_count", 32'(PendingCount), 0);
        chk("rst_ready", 32'(InReady), 1);
        chk("rst_src",   32'(SrcData), 0);
        chk("rst_flags", 32'(CurFlags), 0);

        // accept, forward, then commit to the register file
        DestIdx = 3;
        drive(1, 3, 16'h1234, 0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("fwd_dest3", 32'(DestData), 32'h1234);
        chk("fwd_cnt1",  32'(PendingCount), 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("cmt_cnt0",  32'(PendingCount), 0);
        chk("cmt_dest3", 32'(DestData), 32'h1234);

        // fill both slots with the same index; youngest wins, third offer ignored
        SrcIdx = 2;
        drive(1, 2, 16'h0001, 0, 1, 0, 0); tick();
        drive(1, 2, 16'h00FF, 0, 1, 0, 0); tick();
        drive(1, 2, 16'hBEEF, 0, 1, 0, 0);
        #1;
        chk("full_cnt",   32'(PendingCount), 2);
        chk("full_ready", 32'(InReady), 0);
        chk("full_src2",  32'(SrcData), 32'h00FF);
        tick();
        #1;
        chk("ign_cnt",  32'(PendingCount), 2);
        chk("ign_src2", 32'(SrcData), 32'h00FF);

        // drain to one entry, then simultaneous accept and commit
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        drive(1, 2, 16'h0ABC, 0, 1, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("sim_cnt",  32'(PendingCount), 1);
        chk("sim_src2", 32'(SrcData), 32'h0ABC);
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("sim_rf2", 32'(SrcData), 32'h0ABC);

        // flags-only entry
        SrcIdx = 5;
        drive(1, 5, 16'h7777, 5'b11000, 0, 1, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("fl_cur",  32'(CurFlags), 32'b11000);
        chk("fl_reg5", 32'(SrcData), 0);
        drive(0, 0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("fl_cmt", 32'(CurFlags), 32'b11000);

        // reset with two pending entries, overriding accept/commit
        drive(1, 1, 16'h1111, 5'b00111, 1, 1, 0); tick();
        drive(1, 4, 16'h4444, 0, 1, 0, 0); tick();
        Reset = 1'b1;
        drive(1, 6, 16'h6666, 5'b10101, 1, 1, 1); tick();
        Reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("mrst_cnt",   32'(PendingCount), 0);
        chk("mrst_ready", 32'(InReady), 1);
        chk("mrst_flags", 32'(CurFlags), 0);
        for (int i = 0; i < 8; i++) begin
            SrcIdx = 3'(i); DestIdx = 3'(7 - i);
            #1;
            chk("mrst_src",  32'(SrcData), 0);
            chk("mrst_dest", 32'(DestData), 0);
        end

        // commit requests while empty
        drive(0, 0, 0, 0, 0, 0, 1);
        tick(); tick(); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("empty_cnt", 32'(PendingCount), 0);
        chk("empty_src", 32'(SrcData), 0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            Reset = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 9) < 7, 3'($urandom), 16'($urandom), 5'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(0, 9) < 5);
            SrcIdx  = 3'($urandom);
            DestIdx = ($urandom_range(0, 3) == 0) ? SrcIdx : 3'($urandom);
            tick();
        end
        Reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
